sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_arb_pkg.sv | 25 ++
 rtl/sram_arb_pick.sv | 43 ++++
 rtl/sram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, owner encoding
// and the latched transfer bundle.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Priority pick between inst and data requesters, data first unless
// inst has lost STARVE_LIMIT grants in a row.
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       grant_en,
  output logic [1:0] grant,
  output logic [3:0] starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic starved;

  assign starved = (starve_cnt == LIMIT);

  // grant[0] = inst, grant[1] = data
  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      if (inst_req && (!data_req || starved))
        grant[0] = 1'b1;
      else if (data_req)
        grant[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      starve_cnt <= 4'd0;
    else if (grant[0])
      starve_cnt <= 4'd0;
    else if (grant[1] && inst_req && !starved)
      starve_cnt <= starve_cnt + 4'd1;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like port arbiter with a
// single outstanding transaction and starvation-bounded priority.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata
);

  state_t     state;
  owner_t     owner;
  xfer_t      xfer;
  logic [1:0] grant;
  logic [3:0] starve_cnt;
  logic       grant_en;

  assign grant_en = resetn && (state == IDLE);

  sram_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk       (clk),
    .resetn    (resetn),
    .inst_req  (inst_req),
    .data_req  (data_req),
    .grant_en  (grant_en),
    .grant     (grant),
    .starve_cnt(starve_cnt)
  );

  assign inst_addr_ok = grant[0];
  assign data_addr_ok = grant[1];

  assign s_wr    = xfer.wr;
  assign s_size  = xfer.size;
  assign s_addr  = xfer.addr;
  assign s_wdata = xfer.wdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      owner        <= OWN_INST;
      xfer         <= '0;
      s_req        <= 1'b0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant[1]) begin
            owner <= OWN_DATA;
            xfer  <= '{data_wr, data_size, data_addr, data_wdata};
            s_req <= 1'b1;
            state <= ADDR;
          end else if (grant[0]) begin
            owner <= OWN_INST;
            xfer  <= '{inst_wr, inst_size, inst_addr, inst_wdata};
            s_req <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (s_addr_ok) begin
            s_req <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (s_data_ok) begin
            if (owner == OWN_DATA) begin
              data_rdata   <= s_rdata;
              data_data_ok <= 1'b1;
            end else begin
              inst_rdata   <= s_rdata;
              inst_data_ok <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  starve_bound: assert property (
    @(posedge clk) disable iff (!resetn)
    starve_cnt <= 4'(STARVE_LIMIT)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_wr     (inst_wr),
    .inst_size   (inst_size),
    .inst_addr   (inst_addr),
    .inst_wdata  (inst_wdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .s_req       (s_req),
    .s_wr        (s_wr),
    .s_size      (s_size),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_addr_ok   (s_addr_ok),
    .s_data_ok   (s_data_ok),
    .s_rdata     (s_rdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // 1 = data grant, 0 = inst grant
  bit exp_data [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    logic [1:0] prev_ok;
    resetn = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd0;
    inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = '0; data_wdata = '0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;

    // reset: addr_ok masked even with a request pending
    tick(); tick();
    smp();
    check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    check("rst_s_req", s_req, 1'b0);
    check("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check("rst_rdata", inst_rdata | data_rdata, 32'd0);

    // lone inst read
    tick();
    resetn = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
    smp();
    check("ir_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
    tick();
    inst_req = 1'b0; inst_addr = 32'h0;
    s_addr_ok = 1'b1;
    smp();
    check("ir_s_req", s_req, 1'b1);
    check("ir_s_addr", s_addr, 32'hBFC0_0000);
    check("ir_s_wr", s_wr, 1'b0);
    tick();
    s_addr_ok = 1'b0;
    smp();
    check("ir_s_req_drop", s_req, 1'b0);
    tick();
    s_data_ok = 1'b1; s_rdata = 32'h3C1D_0001;
    smp();
    check("ir_early_ok", {inst_data_ok, data_data_ok}, 2'b00);
    tick();
    s_data_ok = 1'b0;
    smp();
    check("ir_data_ok", {inst_data_ok, data_data_ok}, 2'b10);
    check("ir_rdata", inst_rdata, 32'h3C1D_0001);
    tick();

    // both requesters held, 1-cycle downstream
    inst_req = 1'b1; data_req = 1'b1;
    s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h0000_1111;
    for (int k = 0; k < 10; k++) begin
      smp();
      if (k == 0) prev_ok = 2'b00;
      else prev_ok = exp_data[k-1] ? 2'b01 : 2'b10;
      check($sformatf("starve_ok%0d", k),
            {inst_data_ok, data_data_ok}, prev_ok);
      check($sformatf("starve_gnt%0d", k),
            {inst_addr_ok, data_addr_ok},
            exp_data[k] ? 2'b01 : 2'b10);
      if (k == 4) check("starve_cnt_max", dut.u_pick.starve_cnt, 4'd4);
      tick();
      if (k == 9) begin
        inst_req = 1'b0; data_req = 1'b0;
      end
      tick();
      tick();
    end
    s_addr_ok = 1'b0; s_data_ok = 1'b0;
    smp();
    check("starve_last_ok", {inst_data_ok, data_data_ok}, 2'b10);
    check("starve_rdata", inst_rdata, 32'h0000_1111);
    check("starve_cnt_clr", dut.u_pick.starve_cnt, 4'd0);
    tick();

    // data write with s_addr_ok delayed 3 cycles
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    smp();
    check("dw_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
    tick();
    for (int i = 0; i < 3; i++) begin
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
      data_addr = 32'h0; data_wdata = 32'h0;
      s_addr_ok = (i == 2);
      smp();
      check($sformatf("dw_s_req%0d", i), s_req, 1'b1);
      check($sformatf("dw_s_addr%0d", i), s_addr, 32'h8000_0010);
      check($sformatf("dw_s_wdata%0d", i), s_wdata, 32'hDEAD_BEEF);
      check($sformatf("dw_s_ctl%0d", i), {s_wr, s_size}, 3'b110);
      tick();
    end
    s_addr_ok = 1'b0;
    smp();
    check("dw_s_req_drop", s_req, 1'b0);
    s_data_ok = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    s_data_ok = 1'b0;
    smp();
    check("dw_data_ok", {inst_data_ok, data_data_ok}, 2'b01);
    check("dw_rdata", data_rdata, 32'h1234_5678);
    check("dw_inst_rdata", inst_rdata, 32'h0000_1111);
    tick();
    smp();
    check("dw_one_pulse", {inst_data_ok, data_data_ok}, 2'b00);

    // spurious s_data_ok in IDLE
    s_data_ok = 1'b1; s_rdata = 32'hFFFF_FFFF;
    tick();
    s_data_ok = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h100;
    smp();
    check("sp_idle_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check("sp_idle_rdata", data_rdata, 32'h1234_5678);
    check("sp_gnt", {inst_addr_ok, data_addr_ok}, 2'b01);
    tick();

    // spurious s_data_ok in ADDR
    for (int i = 0; i < 2; i++) begin
      s_data_ok = 1'b1;
      smp();
      check($sformatf("sp_addr_aok%0d", i),
            {inst_addr_ok, data_addr_ok}, 2'b00);
      check($sformatf("sp_addr_ok%0d", i),
            {inst_data_ok, data_data_ok}, 2'b00);
      tick();
    end
    s_data_ok = 1'b0; s_addr_ok = 1'b1;
    smp();
    check("sp_addr_ok_late", {inst_data_ok, data_data_ok}, 2'b00);
    check("sp_addr_rdata", data_rdata, 32'h1234_5678);
    tick();
    s_addr_ok = 1'b0;
    smp();
    check("wait_s_req", s_req, 1'b0);
    check("wait_cnt", dut.u_pick.starve_cnt, 4'd1);

    // reset while in WAIT
    resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    tick();
    resetn = 1'b1;
    s_data_ok = 1'b1; s_rdata = 32'h0000_0055;
    smp();
    check("rw_s_req", s_req, 1'b0);
    check("rw_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check("rw_cnt", dut.u_pick.starve_cnt, 4'd0);
    check("rw_rdata", inst_rdata | data_rdata, 32'd0);
    tick();
    s_data_ok = 1'b0;
    inst_req = 1'b1;
    smp();
    check("rw_late_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check("rw_regrant", {inst_addr_ok, data_addr_ok}, 2'b10);
    tick();
    inst_req = 1'b0;
    smp();
    check("rw_s_req_new", s_req, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
